// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared opcodes, frame widths and FSM encoding for the SPI initiator
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    TURN,
    RX,
    GAP
  } state_e;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host command/response handshake plus SPI pins
interface spi_master_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              sclk;
  logic              ss_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  cmd_valid, cmd, miso,
    output cmd_ready, rsp_valid, rsp_data, busy, sclk, ss_n, mosi
  );

  modport slave (
    output cmd_valid, cmd, miso,
    input  cmd_ready, rsp_valid, rsp_data, busy, sclk, ss_n, mosi
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter driving sclk with rise/fall strobes
module spi_sclk_gen #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic sclk_en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // Strobes flag the cycle whose closing edge moves sclk; clr only affects state
  assign tick_o = en_i && (cnt_q == CNT_MAX);
  assign rise_o = tick_o && sclk_en_i && !sclk_q;
  assign fall_o = tick_o && sclk_en_i && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      if (rise_o || fall_o) sclk_d = !sclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI initiator issuing 10-bit commands and capturing 8-bit replies
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int TURN_BITS = 2
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master bus
);

  localparam logic [3:0] CMD_PERIODS  = 4'(CMD_W);
  localparam logic [3:0] TURN_PERIODS = 4'(TURN_BITS);
  localparam logic [3:0] RX_PERIODS   = 4'(DATA_W);
  localparam logic [3:0] GAP_LAST     = 4'd1;

  state_e            state_q, state_d;
  logic [3:0]        bit_q, bit_d;
  logic [1:0]        op_q, op_d;
  logic [CMD_W-1:0]  cmd_sr_q, cmd_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              gen_en, gen_sclk_en, gen_clr;
  logic              sclk, tick, rise, fall;

  assign gen_en      = (state_q != IDLE);
  assign gen_sclk_en = (state_q != GAP);

  spi_sclk_gen #(.HALF(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (gen_en),
    .sclk_en_i (gen_sclk_en),
    .clr_i     (gen_clr),
    .sclk_o    (sclk),
    .tick_o    (tick),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  // Phases end on the rise strobe that would open the next period, so each low half completes
  always_comb begin
    state_d     = state_q;
    bit_d       = fall ? bit_q + 4'd1 : bit_q;
    op_d        = op_q;
    cmd_sr_d    = cmd_sr_q;
    rx_sr_d     = rx_sr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mosi_d      = mosi_q;
    gen_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        gen_clr = 1'b1;
        mosi_d  = 1'b0;
        if (bus.cmd_valid) begin
          state_d  = SETUP;
          bit_d    = '0;
          op_d     = bus.cmd[CMD_W-1 -: 2];
          cmd_sr_d = bus.cmd;
          mosi_d   = bus.cmd[CMD_W-1];
        end
      end
      SETUP: begin
        if (rise) begin
          state_d = CMD;
          bit_d   = '0;
        end
      end
      CMD: begin
        if (fall) begin
          cmd_sr_d = cmd_sr_q << 1;
          mosi_d   = cmd_sr_q[CMD_W-2];
        end
        if (rise && bit_q == CMD_PERIODS) begin
          bit_d = '0;
          if (op_q == OP_RD_DATA) begin
            state_d = TURN;
          end else begin
            state_d = GAP;
            gen_clr = 1'b1;
            mosi_d  = 1'b0;
          end
        end
      end
      TURN: begin
        mosi_d = 1'b0;
        if (rise && bit_q == TURN_PERIODS) begin
          state_d = RX;
          bit_d   = '0;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
        end
      end
      RX: begin
        if (rise) begin
          if (bit_q == RX_PERIODS) begin
            state_d     = GAP;
            bit_d       = '0;
            gen_clr     = 1'b1;
            rsp_data_d  = rx_sr_q;
            rsp_valid_d = 1'b1;
          end else begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
          end
        end
      end
      GAP: begin
        mosi_d = 1'b0;
        if (tick) begin
          if (bit_q == GAP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ss_n_d  = (state_d == IDLE) || (state_d == GAP);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      op_q        <= OP_WR_ADDR;
      cmd_sr_q    <= '0;
      rx_sr_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      op_q        <= op_d;
      cmd_sr_q    <= cmd_sr_d;
      rx_sr_q     <= rx_sr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.sclk      = sclk;
  assign bus.ss_n      = ss_n_q;
  assign bus.mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - table-driven frame checks plus reset, back-to-back and abort sequences
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miso_q = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int s_rises = 0;
  int acc_cnt = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  spi_master_if sif ();

  spi_master #(.CLK_DIV(2), .TURN_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.master)
  );

  always #5 clk = ~clk;

  assign sif.miso = miso_q;

  // Slave model: 10 command + 2 dummy rises, then reply MSB first, changed on sclk falls
  always @(posedge sif.sclk or negedge sif.ss_n) begin
    if (sif.sclk) s_rises = s_rises + 1;
    else s_rises = 0;
  end

  always @(negedge sif.sclk) begin
    if (s_rises >= 12 && s_rises < 20) miso_q = slave_byte[19 - s_rises];
    else miso_q = 1'b1;
  end

  always @(posedge clk) begin
    if (rst_n && sif.cmd_valid && sif.cmd_ready) acc_cnt = acc_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  typedef struct {
    logic [9:0] cmd;
    logic [7:0] reply;
    int         rises;
    int         ss_low;
    int         ready_at;
    int         rsp_cnt;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[6];

  // Drives one command, toggles cmd_valid/cmd while busy, and observes the frame until cmd_ready
  task automatic run_frame(input logic [9:0] c, input logic [7:0] reply,
                           output int rises, output int ss_low, output int ready_at,
                           output int rsp_cnt, output int rsp_on_rise,
                           output logic [9:0] mosi_bits, output int busy_gaps);
    logic prev_sclk;
    logic prev_ss;
    rises = 0; ss_low = 0; ready_at = -1; rsp_cnt = 0; rsp_on_rise = 0;
    mosi_bits = '0; busy_gaps = 0;
    slave_byte = reply;
    @(negedge clk);
    sif.cmd = c;
    sif.cmd_valid = 1'b1;
    @(negedge clk);
    sif.cmd_valid = 1'b0;
    sif.cmd = ~c;
    prev_sclk = 1'b0;
    prev_ss = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      if (sif.sclk && !prev_sclk) begin
        if (rises < 10) mosi_bits = {mosi_bits[8:0], sif.mosi};
        rises++;
      end
      if (!sif.ss_n) ss_low++;
      if (sif.rsp_valid) begin
        rsp_cnt++;
        if (sif.ss_n && !prev_ss) rsp_on_rise++;
      end
      if (sif.cmd_ready) begin
        ready_at = n;
        sif.cmd_valid = 1'b0;
        break;
      end
      if (!sif.busy) busy_gaps++;
      sif.cmd_valid = n[0];
      sif.cmd = 10'(n * 37);
      prev_sclk = sif.sclk;
      prev_ss = sif.ss_n;
    end
  endtask

  initial begin
    int rises, ss_low, ready_at, rsp_cnt, rsp_on_rise, busy_gaps, cnt_a, cnt_b;
    int r1, r2, hi, f, acc_before;
    logic [9:0] mosi_bits, m1, m2;
    logic prev_sclk, prev_ss;

    vecs[0] = '{10'h0A5, 8'h00, 10, 42, 46, 0, 8'h00};
    vecs[1] = '{10'h300, 8'h3C, 20, 82, 86, 1, 8'h3C};
    vecs[2] = '{10'h1C3, 8'hFF, 10, 42, 46, 0, 8'h3C};
    vecs[3] = '{10'h2FF, 8'h00, 10, 42, 46, 0, 8'h3C};
    vecs[4] = '{10'h3AA, 8'hC5, 20, 82, 86, 1, 8'hC5};
    vecs[5] = '{10'h355, 8'h81, 20, 82, 86, 1, 8'h81};

    sif.cmd_valid = 1'b0;
    sif.cmd = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ss_n", int'(sif.ss_n), 1);
    check("reset sclk", int'(sif.sclk), 0);
    check("reset mosi", int'(sif.mosi), 0);
    check("reset cmd_ready", int'(sif.cmd_ready), 1);
    check("reset rsp_valid", int'(sif.rsp_valid), 0);
    check("reset rsp_data", int'(sif.rsp_data), 0);
    check("reset busy", int'(sif.busy), 0);
    rst_n = 1'b1;
    cnt_a = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!sif.ss_n || sif.sclk || sif.busy) cnt_a++;
    end
    check("idle after reset activity", cnt_a, 0);

    // Abort a read after its 5th sclk rise
    slave_byte = 8'h5A;
    @(negedge clk);
    sif.cmd = 10'h300;
    sif.cmd_valid = 1'b1;
    @(negedge clk);
    sif.cmd_valid = 1'b0;
    rises = 0;
    prev_sclk = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) @(negedge clk);
      if (sif.sclk && !prev_sclk) rises++;
      prev_sclk = sif.sclk;
      if (rises == 5) break;
    end
    check("abort reached 5th rise", rises, 5);
    rst_n = 1'b0;
    #1;
    check("abort ss_n immediate", int'(sif.ss_n), 1);
    check("abort sclk immediate", int'(sif.sclk), 0);
    check("abort cmd_ready", int'(sif.cmd_ready), 1);
    cnt_a = 0;
    cnt_b = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sif.rsp_valid) cnt_a++;
      if (!sif.ss_n) cnt_b++;
    end
    check("abort no rsp_valid", cnt_a, 0);
    check("abort ss_n stays high", cnt_b, 0);
    check("abort rsp_data", int'(sif.rsp_data), 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].cmd, vecs[i].reply, rises, ss_low, ready_at, rsp_cnt,
                rsp_on_rise, mosi_bits, busy_gaps);
      check($sformatf("v%0d sclk rises", i), rises, vecs[i].rises);
      check($sformatf("v%0d mosi bits", i), int'(mosi_bits), int'(vecs[i].cmd));
      check($sformatf("v%0d ss_n low cycles", i), ss_low, vecs[i].ss_low);
      check($sformatf("v%0d cmd_ready return", i), ready_at, vecs[i].ready_at);
      check($sformatf("v%0d rsp_valid count", i), rsp_cnt, vecs[i].rsp_cnt);
      check($sformatf("v%0d rsp_valid at ss_n rise", i), rsp_on_rise, vecs[i].rsp_cnt);
      check($sformatf("v%0d busy drop in frame", i), busy_gaps, 0);
      check($sformatf("v%0d rsp_data", i), int'(sif.rsp_data), int'(vecs[i].data));
    end

    // Back-to-back: cmd_valid held high, cmd changed mid-frame
    acc_before = acc_cnt;
    slave_byte = 8'h00;
    @(negedge clk);
    sif.cmd = 10'h112;
    sif.cmd_valid = 1'b1;
    @(negedge clk);
    sif.cmd = 10'h2FF;
    r1 = 0; r2 = 0; hi = 0; f = 1; m1 = '0; m2 = '0; cnt_a = 0;
    prev_sclk = 1'b0;
    prev_ss = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (n > 0) @(negedge clk);
      if (acc_cnt - acc_before >= 2) sif.cmd_valid = 1'b0;
      if (!sif.ss_n && prev_ss) f = 2;
      if (sif.ss_n && f == 1) hi++;
      if (sif.sclk && !prev_sclk) begin
        if (f == 1) begin
          if (r1 < 10) m1 = {m1[8:0], sif.mosi};
          r1++;
        end else begin
          if (r2 < 10) m2 = {m2[8:0], sif.mosi};
          r2++;
        end
      end
      if (sif.rsp_valid) cnt_a++;
      prev_sclk = sif.sclk;
      prev_ss = sif.ss_n;
      if (f == 2 && sif.cmd_ready) break;
    end
    sif.cmd_valid = 1'b0;
    check("b2b second frame seen", f, 2);
    check("b2b frame1 mosi", int'(m1), int'(10'h112));
    check("b2b frame1 rises", r1, 10);
    check("b2b ss_n high gap plus accept cycle", hi, 5);
    check("b2b frame2 mosi", int'(m2), int'(10'h2FF));
    check("b2b frame2 rises", r2, 10);
    check("b2b accepts", acc_cnt - acc_before, 2);
    check("b2b no rsp_valid", cnt_a, 0);
    check("b2b cmd_ready at end", int'(sif.cmd_ready), 1);

    repeat (5) @(negedge clk);
    check("total accepts equal frames driven", acc_cnt, 9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
